// File: rtl/iob_sp_ram_be_arb_pkg.sv
// Shared identifiers and width helpers for the two-requester RAM arbiter.
package iob_sp_ram_be_arb_pkg;

    localparam logic ARB_ID_R0 = 1'b0;
    localparam logic ARB_ID_R1 = 1'b1;

    function automatic int data_width(input int num_col, input int col_width);
        return num_col * col_width;
    endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, last winner loses the next tie.
module iob_rr_arb2
    import iob_sp_ram_be_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_gnt_reg;
    logic last_gnt_next;

    always_comb begin
        gnt           = 2'b00;
        last_gnt_next = last_gnt_reg;
        if (req[0] && (!req[1] || last_gnt_reg == ARB_ID_R1)) begin
            gnt           = 2'b01;
            last_gnt_next = ARB_ID_R0;
        end else if (req[1]) begin
            gnt           = 2'b10;
            last_gnt_next = ARB_ID_R1;
        end
    end

    // Reset to R1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg <= ARB_ID_R1;
        end else begin
            last_gnt_reg <= last_gnt_next;
        end
    end

endmodule

// File: rtl/iob_sp_ram_be_arb.sv
// Shares one single-port byte-enable RAM between two valid/ready requesters.
module iob_sp_ram_be_arb
    import iob_sp_ram_be_arb_pkg::*;
#(
    parameter  int NUM_COL    = 4,
    parameter  int COL_WIDTH  = 8,
    parameter  int ADDR_WIDTH = 10,
    localparam int DATA_WIDTH = data_width(NUM_COL, COL_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_valid,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [NUM_COL-1:0]    r0_wstrb,
    output logic                  r0_ready,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_valid,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [NUM_COL-1:0]    r1_wstrb,
    output logic                  r1_ready,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  ram_en,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] addr_vec  [2];
    logic [DATA_WIDTH-1:0] wdata_vec [2];
    logic [NUM_COL-1:0]    wstrb_vec [2];
    logic                  sel;
    logic                  rsp_pend_reg;
    logic                  rsp_id_reg;
    logic [1:0]            rvalid_vec;
    logic [DATA_WIDTH-1:0] rdata_vec [2];

    assign req          = {r1_valid, r0_valid};
    assign addr_vec[0]  = r0_addr;
    assign addr_vec[1]  = r1_addr;
    assign wdata_vec[0] = r0_wdata;
    assign wdata_vec[1] = r1_wdata;
    assign wstrb_vec[0] = r0_wstrb;
    assign wstrb_vec[1] = r1_wstrb;

    iob_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign sel      = gnt[1];
    assign r0_ready = gnt[0];
    assign r1_ready = gnt[1];

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt != 2'b00) begin
            ram_en   = 1'b1;
            ram_we   = wstrb_vec[sel];
            ram_addr = addr_vec[sel];
            ram_din  = wdata_vec[sel];
        end
    end

    // RAM latency is fixed at one cycle, so one pending slot is enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pend_reg <= 1'b0;
            rsp_id_reg   <= ARB_ID_R0;
        end else begin
            rsp_pend_reg <= ram_en && (ram_we == '0);
            rsp_id_reg   <= sel ? ARB_ID_R1 : ARB_ID_R0;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic [DATA_WIDTH-1:0] rdata_reg;

        // Reset in the response cycle drops the pending pulse immediately.
        assign rvalid_vec[gi] = rsp_pend_reg && (rsp_id_reg == 1'(gi)) && !rst;
        assign rdata_vec[gi]  = rvalid_vec[gi] ? ram_dout : rdata_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_reg <= '0;
            end else if (rvalid_vec[gi]) begin
                rdata_reg <= ram_dout;
            end
        end
    end

    assign r0_rvalid = rvalid_vec[0];
    assign r1_rvalid = rvalid_vec[1];
    assign r0_rdata  = rdata_vec[0];
    assign r1_rdata  = rdata_vec[1];

endmodule

// File: tb/tb_iob_sp_ram_be_arb.sv
// Directed bench for iob_sp_ram_be_arb with a behavioural read-first byte-enable RAM.
module tb_iob_sp_ram_be_arb;

    localparam int NC = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r1_valid;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic [NC-1:0] r0_wstrb, r1_wstrb;
    logic          r0_ready, r1_ready, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          ram_en;
    logic [NC-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [DW-1:0] mem [16];
    logic [DW-1:0] vals [4];

    always #5 clk = ~clk;

    // Read-first RAM model: dout returns the pre-write contents.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= mem[ram_addr];
            for (int i = 0; i < NC; i++) begin
                if (ram_we[i]) mem[ram_addr][i*8 +: 8] <= ram_din[i*8 +: 8];
            end
        end
    end

    iob_sp_ram_be_arb #(.NUM_COL(NC), .COL_WIDTH(8), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
        .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
        .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NC-1:0] s);
        r0_valid = v; r0_addr = a; r0_wdata = d; r0_wstrb = s;
    endtask

    task automatic drv1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NC-1:0] s);
        r1_valid = v; r1_addr = a; r1_wdata = d; r1_wstrb = s;
    endtask

    task automatic idle();
        drv0(1'b0, '0, '0, '0);
        drv1(1'b0, '0, '0, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        ram_dout = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        vals[0] = 32'h0102_0304; vals[1] = 32'h5566_7788;
        vals[2] = 32'h9ABC_DEF0; vals[3] = 32'h0F1E_2D3C;
        #1;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_r0_rvalid", 32'(r0_rvalid), 0);
        chk("rst_r1_rvalid", 32'(r1_rvalid), 0);
        chk("rst_r0_rdata", r0_rdata, 0);
        chk("rst_r1_rdata", r1_rdata, 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        $display("reset: state checked");
        next_cycle();

        // 1: write then read back
        drv0(1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        chk("t1_wr_ready", 32'(r0_ready), 1);
        chk("t1_wr_we", 32'(ram_we), 32'hF);
        chk("t1_wr_addr", 32'(ram_addr), 3);
        next_cycle();
        drv0(1'b1, 4'd3, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_rd_ready", 32'(r0_ready), 1);
        chk("t1_wr_no_rvalid", 32'(r0_rvalid), 0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t1_rvalid", 32'(r0_rvalid), 1);
        chk("t1_rdata", r0_rdata, 32'hDEAD_BEEF);
        chk("t1_r1_rvalid", 32'(r1_rvalid), 0);
        $display("t1: write/read @3 rdata=%h", r0_rdata);
        next_cycle();
        @(negedge clk);
        chk("t1_rvalid_pulse", 32'(r0_rvalid), 0);
        chk("t1_rdata_hold", r0_rdata, 32'hDEAD_BEEF);

        // 2: continuous tie alternates 0,1,0,1...
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drv0(1'b1, 4'd1, 32'h0, 4'h0);
            drv1(1'b1, 4'd2, 32'h0, 4'h0);
            @(negedge clk);
            chk($sformatf("t2_r0_ready_%0d", i), 32'(r0_ready), 32'((i % 2) == 0));
            chk($sformatf("t2_r1_ready_%0d", i), 32'(r1_ready), 32'((i % 2) == 1));
            $display("t2: slot %0d r0_ready=%0d r1_ready=%0d", i, r0_ready, r1_ready);
            next_cycle();
        end
        idle();

        // 3: partial byte strobes
        drv0(1'b1, 4'd5, 32'h1122_3344, 4'hF);
        next_cycle();
        drv0(1'b1, 4'd5, 32'hAABB_CCDD, 4'b0101);
        next_cycle();
        drv0(1'b1, 4'd5, 32'h0, 4'h0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t3_rvalid", 32'(r0_rvalid), 1);
        chk("t3_rdata", r0_rdata, 32'h11BB_33DD);
        $display("t3: partial write @5 rdata=%h", r0_rdata);
        next_cycle();

        // 4: r0 write and r1 read to same address collide; r0 wins
        drv1(1'b1, 4'd7, 32'h0, 4'h0);
        next_cycle();
        drv0(1'b1, 4'd2, 32'hCAFE_F00D, 4'hF);
        drv1(1'b1, 4'd2, 32'h0, 4'h0);
        @(negedge clk);
        chk("t4_r0_ready", 32'(r0_ready), 1);
        chk("t4_r1_ready", 32'(r1_ready), 0);
        next_cycle();
        drv0(1'b0, '0, '0, '0);
        @(negedge clk);
        chk("t4_r1_ready2", 32'(r1_ready), 1);
        chk("t4_r0_no_rvalid", 32'(r0_rvalid), 0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("t4_r1_rvalid", 32'(r1_rvalid), 1);
        chk("t4_r1_rdata", r1_rdata, 32'hCAFE_F00D);
        chk("t4_r0_rvalid", 32'(r0_rvalid), 0);
        chk("t4_r0_rdata_hold", r0_rdata, 32'h11BB_33DD);
        $display("t4: collision r1 rdata=%h", r1_rdata);
        next_cycle();

        // 5: reset right after a read accept
        drv0(1'b1, 4'd3, 32'h0, 4'h0);
        next_cycle();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rvalid_dropped", 32'(r0_rvalid), 0);
        next_cycle();
        rst = 1'b0;
        drv0(1'b1, 4'd1, 32'h0, 4'h0);
        drv1(1'b1, 4'd1, 32'h0, 4'h0);
        @(negedge clk);
        chk("t5_tie_r0_ready", 32'(r0_ready), 1);
        chk("t5_tie_r1_ready", 32'(r1_ready), 0);
        chk("t5_r0_rdata_cleared", r0_rdata, 0);
        $display("t5: reset mid-read, tie grants r0");
        next_cycle();
        idle();
        next_cycle();

        // 6: sole requester full throughput
        for (int i = 0; i < 4; i++) begin
            drv0(1'b1, 4'(i), vals[i], 4'hF);
            next_cycle();
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drv0(1'b1, 4'(i), 32'h0, 4'h0);
            else idle();
            @(negedge clk);
            if (i < 4) chk($sformatf("t6_ready_%0d", i), 32'(r0_ready), 1);
            if (i > 0) begin
                chk($sformatf("t6_rvalid_%0d", i), 32'(r0_rvalid), 1);
                chk($sformatf("t6_rdata_%0d", i), r0_rdata, vals[i-1]);
                $display("t6: read @%0d rdata=%h", i - 1, r0_rdata);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("t6_rvalid_end", 32'(r0_rvalid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
